rx_psdu_deframer: RTL
=====================

# rx_psdu_deframer

Receive-side PSDU deframer for the 802.11a PHY. It sits directly downstream of the descrambler and consumes its serial output bit stream. It checks and strips the 16-bit SERVICE field, packs the PSDU bits LSB-first into bytes, counts exactly LENGTH bytes, and then discards the tail and pad bits. Its byte stream feeds the MAC-side receive interface.

## Interface

Parameters:
- SERVICE_BITS, 16, number of leading SERVICE bits stripped and checked
- LENGTH_WIDTH, 12, width of the PSDU byte-count input (802.11a LENGTH field)

Ports:
- clock  in  1  single clock; all logic rising-edge
- Deframer_Reset_n  in  1  asynchronous, active-low reset
- Deframer_Start  in  1  one-cycle pulse; begins a new frame and latches Deframer_Length
- Deframer_Length  in  LENGTH_WIDTH  PSDU length in bytes (0..4095), from the decoded SIGNAL field
- Deframer_DataIN  in  1  descrambled bit (descrambler DataOUT)
- Deframer_DataIN_VALID  in  1  qualifies Deframer_DataIN (descrambler DataVALID)
- Deframer_ByteOUT  out  8  assembled PSDU byte, first received bit in bit 0
- Deframer_ByteVALID  out  1  one-cycle qualifier for Deframer_ByteOUT
- Deframer_LastByte  out  1  high with ByteVALID on byte LENGTH-1
- Deframer_Done  out  1  one-cycle pulse when the frame's PSDU is complete
- Deframer_ServiceError  out  1  sticky; a SERVICE bit was 1 (indicates a bad seed or corrupt SERVICE)
- Deframer_Busy  out  1  high in SERVICE and PSDU states

## Operation

- FSM states are IDLE, SERVICE, PSDU and DISCARD. The reset state is IDLE.
- Start behaviour:
  - Start in any state clears the bit counter, byte counter, shift register and ServiceError, latches Length, and moves to SERVICE.
  - Start aborts any frame in progress. No Done is generated for the aborted frame.
  - Start has priority over DataIN_VALID in the same cycle. That cycle's bit is dropped.
- IDLE: ignores all data.
- SERVICE:
  - Counts valid bits 0..SERVICE_BITS-1.
  - Any valid bit equal to 1 sets ServiceError.
  - After bit SERVICE_BITS-1:
    - If Length = 0: pulse Done and go to DISCARD.
    - Otherwise go to PSDU.
- PSDU:
  - On each valid bit: shift[bitcnt] <= DataIN, and bitcnt increments mod 8.
  - On the bit where bitcnt = 7: present {DataIN, shift[6:0]} on ByteOUT with ByteVALID, and increment bytecnt.
  - When that byte is byte Length-1: also assert LastByte and Done, then go to DISCARD.
- DISCARD:
  - Consumes tail and pad bits silently. No output activity.
  - Stays here until the next Start.
- Counters:
  - bitcnt is 3 bits and wraps 7→0.
  - bytecnt is LENGTH_WIDTH bits. Compare bytecnt == latched Length - 1 using the latched value; Length = 0 never reaches PSDU.
- ServiceError stays valid after Done and clears only on Start or reset. Bytes are still delivered when it is set.
- Gaps in DataIN_VALID simply stall the state machine and counters. Gaps have no other effect.

## Timing

- All outputs are registered.
- Async reset (Deframer_Reset_n low), effective immediately:
  - ByteOUT = 0, and ByteVALID, LastByte, Done, ServiceError and Busy = 0.
  - State = IDLE and all counters = 0.
- Latency:
  - ByteVALID is high in the cycle after the edge that samples the 8th bit of the byte.
  - ServiceError rises in the cycle after the offending bit is sampled.
- ByteOUT holds 0 whenever ByteVALID is low. ByteVALID, LastByte and Done are single-cycle pulses.
- Done:
  - Is coincident with LastByte and ByteVALID for Length ≥ 1.
  - For Length = 0, it follows the last SERVICE bit by one cycle.
- Busy:
  - Rises the cycle after Start.
  - Falls in the same cycle Done is asserted (transition out of PSDU or SERVICE).
- Maximum throughput is one bit per cycle, i.e. one byte every 8 cycles.
- Reset asserted mid-frame abandons the frame. No partial byte and no Done are produced.

## Test plan

- Basic frame:
  - Stimulus: Start with Length=2, then 16 zero SERVICE bits, then 1,0,1,0,0,1,0,1 and 0,0,1,1,1,1,0,0, then 6 tail bits, all with continuous valid.
  - Required: ByteOUT=0xA5, then ByteOUT=0x3C with LastByte=1 and Done=1. ServiceError=0, no further ByteVALID, Busy=0 after Done.
- SERVICE check:
  - Stimulus: as the basic frame but with SERVICE bit 3 = 1.
  - Required: ServiceError=1 from the cycle after that bit, held through Done. Bytes 0xA5 and 0x3C are still delivered.
- Gapped valid:
  - Stimulus: the basic frame with DataIN_VALID low every other cycle, with garbage on DataIN while invalid.
  - Required: identical byte sequence and flags. Byte spacing is 16 cycles.
- Length=0:
  - Stimulus: Start with Length=0, then 16 zero bits, then 20 further valid bits.
  - Required: a single Done pulse one cycle after the 16th bit. ByteVALID never asserts.
- Abort and restart:
  - Stimulus: Start with Length=4. After 1 byte plus 3 bits, assert Start with Length=1 in the same cycle as a valid bit, then send 16 zeros and 0xFF.
  - Required: the in-flight bit is dropped and no Done is produced for the first frame. The second frame yields 0xFF with LastByte and Done.
- Async reset:
  - Stimulus: drop Deframer_Reset_n between clock edges mid-PSDU, then release.
  - Required: all outputs 0 immediately, Busy=0, and no output activity until the next Start.

Source files
------------

// File: rtl/rx_psdu_deframer.sv
// ---------------------------------------------------------------------------
// rx_psdu_deframer
//
// Receive-side PSDU deframer for the 802.11a PHY. It takes the serial bit
// stream coming out of the descrambler and does the following:
//   - strips the SERVICE field and checks that every SERVICE bit is zero,
//   - packs the PSDU bits LSB-first into bytes,
//   - delivers exactly LENGTH bytes,
//   - silently swallows the tail and pad bits that follow.
//
// Parameters:
//   SERVICE_BITS           number of leading SERVICE bits stripped and checked
//   LENGTH_WIDTH           width of the PSDU byte-count input
//
// Ports:
//   clock                  rising-edge clock
//   Deframer_Reset_n       asynchronous active-low reset
//   Deframer_Start         one-cycle pulse; starts a frame and latches Length
//   Deframer_Length        PSDU length in bytes
//   Deframer_DataIN        descrambled input bit
//   Deframer_DataIN_VALID  qualifies Deframer_DataIN
//   Deframer_ByteOUT       assembled byte (first received bit in bit 0), 0 when idle
//   Deframer_ByteVALID     one-cycle qualifier for Deframer_ByteOUT
//   Deframer_LastByte      high with ByteVALID on the final PSDU byte
//   Deframer_Done          one-cycle pulse when the PSDU is complete
//   Deframer_ServiceError  sticky flag; some SERVICE bit was 1
//   Deframer_Busy          high while in the SERVICE or PSDU states
// ---------------------------------------------------------------------------
module rx_psdu_deframer #(
   parameter int SERVICE_BITS = 16,
   parameter int LENGTH_WIDTH = 12
) (
   input  logic                    clock,
   input  logic                    Deframer_Reset_n,
   input  logic                    Deframer_Start,
   input  logic [LENGTH_WIDTH-1:0] Deframer_Length,
   input  logic                    Deframer_DataIN,
   input  logic                    Deframer_DataIN_VALID,
   output logic [7:0]              Deframer_ByteOUT,
   output logic                    Deframer_ByteVALID,
   output logic                    Deframer_LastByte,
   output logic                    Deframer_Done,
   output logic                    Deframer_ServiceError,
   output logic                    Deframer_Busy
);

   localparam int SVC_W = (SERVICE_BITS > 1) ? $clog2(SERVICE_BITS) : 1;
   localparam logic [SVC_W-1:0] SVC_LAST = SVC_W'(SERVICE_BITS - 1);
   localparam logic [LENGTH_WIDTH-1:0] LEN_ONE = LENGTH_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE,
      SERVICE,
      PSDU,
      DISCARD
   } state_t;

   state_t                  state_q, state_d;
   logic [SVC_W-1:0]        svcCnt_q, svcCnt_d;
   logic [2:0]              bitCnt_q, bitCnt_d;
   logic [LENGTH_WIDTH-1:0] byteCnt_q, byteCnt_d;
   logic [LENGTH_WIDTH-1:0] length_q, length_d;
   logic [6:0]              shift_q, shift_d;
   logic [7:0]              byteOut_q, byteOut_d;
   logic                    byteValid_q, byteValid_d;
   logic                    lastByte_q, lastByte_d;
   logic                    done_q, done_d;
   logic                    svcErr_q, svcErr_d;
   logic                    busy_q, busy_d;

   // Next-state logic. Start wins over everything, including a valid bit in
   // the same cycle, which is simply dropped. Outputs are computed here as
   // next values so that every output leaves the block straight from a flop.
   // Only bits 0..6 are kept in the shift register: the eighth bit goes
   // directly into the output byte in the same cycle it arrives.
   always_comb begin
      state_d     = state_q;
      svcCnt_d    = svcCnt_q;
      bitCnt_d    = bitCnt_q;
      byteCnt_d   = byteCnt_q;
      length_d    = length_q;
      shift_d     = shift_q;
      byteOut_d   = 8'h00;
      byteValid_d = 1'b0;
      lastByte_d  = 1'b0;
      done_d      = 1'b0;
      svcErr_d    = svcErr_q;

      if (Deframer_Start) begin
         state_d   = SERVICE;
         svcCnt_d  = '0;
         bitCnt_d  = '0;
         byteCnt_d = '0;
         shift_d   = '0;
         svcErr_d  = 1'b0;
         length_d  = Deframer_Length;
      end else if (Deframer_DataIN_VALID) begin
         unique case (state_q)
            SERVICE: begin
               if (Deframer_DataIN) begin
                  svcErr_d = 1'b1;
               end
               if (svcCnt_q == SVC_LAST) begin
                  svcCnt_d = '0;
                  if (length_q == '0) begin
                     done_d  = 1'b1;
                     state_d = DISCARD;
                  end else begin
                     state_d = PSDU;
                  end
               end else begin
                  svcCnt_d = svcCnt_q + SVC_W'(1);
               end
            end
            PSDU: begin
               bitCnt_d = bitCnt_q + 3'd1;
               for (int i = 0; i < 7; i++) begin
                  if (bitCnt_q == 3'(i)) begin
                     shift_d[i] = Deframer_DataIN;
                  end
               end
               if (bitCnt_q == 3'd7) begin
                  byteOut_d   = {Deframer_DataIN, shift_q};
                  byteValid_d = 1'b1;
                  byteCnt_d   = byteCnt_q + LEN_ONE;
                  if (byteCnt_q == length_q - LEN_ONE) begin
                     lastByte_d = 1'b1;
                     done_d     = 1'b1;
                     state_d    = DISCARD;
                  end
               end
            end
            default: begin
            end
         endcase
      end

      // Busy follows the state being entered, so it drops on the same edge
      // that raises Done.
      busy_d = (state_d == SERVICE) || (state_d == PSDU);
   end

   // State and output registers, cleared asynchronously by reset.
   always_ff @(posedge clock or negedge Deframer_Reset_n) begin
      if (!Deframer_Reset_n) begin
         state_q     <= IDLE;
         svcCnt_q    <= '0;
         bitCnt_q    <= '0;
         byteCnt_q   <= '0;
         length_q    <= '0;
         shift_q     <= '0;
         byteOut_q   <= 8'h00;
         byteValid_q <= 1'b0;
         lastByte_q  <= 1'b0;
         done_q      <= 1'b0;
         svcErr_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         svcCnt_q    <= svcCnt_d;
         bitCnt_q    <= bitCnt_d;
         byteCnt_q   <= byteCnt_d;
         length_q    <= length_d;
         shift_q     <= shift_d;
         byteOut_q   <= byteOut_d;
         byteValid_q <= byteValid_d;
         lastByte_q  <= lastByte_d;
         done_q      <= done_d;
         svcErr_q    <= svcErr_d;
         busy_q      <= busy_d;
      end
   end

   assign Deframer_ByteOUT      = byteOut_q;
   assign Deframer_ByteVALID    = byteValid_q;
   assign Deframer_LastByte     = lastByte_q;
   assign Deframer_Done         = done_q;
   assign Deframer_ServiceError = svcErr_q;
   assign Deframer_Busy         = busy_q;

endmodule
